// File: rtl/ram_1kx32_pkg.sv
// Shared sizing for the core data RAM, used by the core, the load/store unit and the RAM itself.
package ram_1kx32_pkg;

  localparam int unsigned RAM_ADDR_WIDTH = 10;
  localparam int unsigned RAM_DATA_WIDTH = 32;
  localparam int unsigned RAM_DEPTH      = 2 ** RAM_ADDR_WIDTH;

  typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
  typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;

endpackage : ram_1kx32_pkg

// File: rtl/ram_1kx32_array.sv
// Plain single-port storage with one write port and a registered read-first output,
// written in the shape FPGA and ASIC memory inference expects.
module ram_1kx32_array
  import ram_1kx32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents are zero; reset never touches the array.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule : ram_1kx32_array

// File: rtl/ram_1kx32.sv
// Core data RAM: 1K x 32 single-port, one-cycle registered read, write-first,
// asynchronous active-high reset that zeroes DATA_OUT and blocks writes but keeps contents.
module ram_1kx32
  import ram_1kx32_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RAM_DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  WRITE_ENABLE,
  input  logic                  CLK,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  input  logic                  RESET
);

  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  r_valid;
  logic                  r_bypass;
  logic [DATA_WIDTH-1:0] r_wdata;

  assign w_we = WRITE_ENABLE & ~RESET;

  ram_1kx32_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_addr  (ADDRESS),
    .i_wdata (DATA_IN),
    .o_rdata (w_rdata)
  );

  // r_valid stays low until the first edge after reset, so DATA_OUT reads 0 until then.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_valid  <= 1'b0;
      r_bypass <= 1'b0;
      r_wdata  <= '0;
    end else begin
      r_valid  <= 1'b1;
      r_bypass <= WRITE_ENABLE;
      if (WRITE_ENABLE) begin
        r_wdata <= DATA_IN;
      end
    end
  end

  // Output is selected purely from registered state; no input reaches DATA_OUT combinationally.
  always_comb begin
    DATA_OUT = '0;
    if (r_valid) begin
      DATA_OUT = r_bypass ? r_wdata : w_rdata;
    end
  end

endmodule : ram_1kx32

// File: tb/tb_ram_1kx32.sv
// Scoreboard bench for ram_1kx32: a reference memory predicts each edge's DATA_OUT.
module tb_ram_1kx32;

  logic [9:0]  address;
  logic [31:0] data_in;
  logic        write_enable;
  logic        clk;
  logic [31:0] data_out;
  logic        reset;

  int unsigned n_checks;
  int unsigned n_fails;

  logic [31:0] mdl [1024];
  logic [31:0] exp_q [$];
  string       tag_q [$];

  ram_1kx32 dut (
    .ADDRESS      (address),
    .DATA_IN      (data_in),
    .WRITE_ENABLE (write_enable),
    .CLK          (clk),
    .DATA_OUT     (data_out),
    .RESET        (reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one op at the falling edge, predict, then compare after the rising edge.
  task automatic do_op(input string tag, input logic we, input logic [9:0] a, input logic [31:0] d);
    logic [31:0] exp;
    string       t;
    @(negedge clk);
    write_enable = we;
    address      = a;
    data_in      = d;
    if (we) begin
      exp    = d;
      mdl[a] = d;
    end else begin
      exp = mdl[a];
    end
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      t = tag_q.pop_front();
      check(t, data_out, exp_q.pop_front());
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fails      = 0;
    for (int i = 0; i < 1024; i++) mdl[i] = '0;
    reset        = 1'b1;
    write_enable = 1'b0;
    address      = '0;
    data_in      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", data_out, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    do_op("unwritten_500", 1'b0, 10'd500, 32'h0);
    do_op("wr_a1_55", 1'b1, 10'd1, 32'd55);
    do_op("wr_a2_99", 1'b1, 10'd2, 32'd99);
    do_op("rd_a1", 1'b0, 10'd1, 32'h0);
    do_op("rd_a2", 1'b0, 10'd2, 32'h0);
    do_op("wr_a0", 1'b1, 10'd0, 32'hDEADBEEF);
    do_op("wr_a1023", 1'b1, 10'd1023, 32'h12345678);
    do_op("rd_a0", 1'b0, 10'd0, 32'h0);
    do_op("rd_a1023", 1'b0, 10'd1023, 32'h0);
    do_op("rd_a1_again", 1'b0, 10'd1, 32'h0);
    do_op("rd_a2_again", 1'b0, 10'd2, 32'h0);
    do_op("wr_a7", 1'b1, 10'd7, 32'hA5A5A5A5);
    do_op("rd_a7_next", 1'b0, 10'd7, 32'h0);
    do_op("wr_a7_zero", 1'b1, 10'd7, 32'h0);
    do_op("rd_a7_zero", 1'b0, 10'd7, 32'h0);
    check("const_a1_55", mdl[1], 32'd55);

    // Hold the last read value, then assert reset between edges.
    do_op("rd_a0_pre_rst", 1'b0, 10'd0, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_now", data_out, 32'h0);
    write_enable = 1'b1;
    address      = 10'd1;
    data_in      = 32'hFFFFFFFF;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_hold_zero", data_out, 32'h0);
    end
    @(negedge clk);
    reset        = 1'b0;
    write_enable = 1'b0;
    do_op("rd_a1_after_rst", 1'b0, 10'd1, 32'h0);
    check("rst_write_blocked", mdl[1], 32'd55);

    // Random mixed traffic over a small window plus the boundary words.
    for (int i = 0; i < 300; i++) begin
      logic [9:0] a;
      case ($urandom_range(0, 5))
        0:       a = 10'd0;
        1:       a = 10'd1023;
        default: a = 10'($urandom_range(0, 15));
      endcase
      do_op("rand_op", 1'($urandom_range(0, 1)), a, $urandom);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule : tb_ram_1kx32
